// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing constants, count widths and colour-scheduler mode encodings.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 56;
  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 37;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10
  } mode_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, parameterised width, cleared by reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_color_sched.sv
// rtl/vga_color_sched.sv - frame-synchronous colour scheduler (manual / auto-cycle / hold).
module vga_color_sched
  import vga_pkg::*;
#(
  parameter int H_TOTAL         = vga_pkg::H_TOTAL,
  parameter int V_TOTAL         = vga_pkg::V_TOTAL,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [H_W-1:0]   h_count,
  input  logic [V_W-1:0]   v_count,
  input  logic [2:0]       sw,
  input  logic             auto_en,
  input  logic             freeze,
  output logic [2:0]       color,
  output logic             frame_tick,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [4:0] raw_in;
  logic [4:0] synced;
  logic [2:0] sw_s;
  logic       auto_en_s;
  logic       freeze_s;

  assign raw_in = {sw, auto_en, freeze};

  sync_2ff #(.WIDTH(5)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (synced)
  );

  assign sw_s      = synced[4:2];
  assign auto_en_s = synced[1];
  assign freeze_s  = synced[0];

  logic last_px;
  assign last_px = (h_count == H_LAST) && (v_count == V_LAST);

  mode_t             mode_q, mode_n;
  logic [2:0]        color_q, color_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              tick_q;

  always_comb begin
    mode_n  = mode_q;
    color_n = color_q;
    cnt_n   = cnt_q;
    if (freeze_s) begin
      mode_n = MODE_HOLD;
    end else if (auto_en_s) begin
      mode_n = MODE_AUTO;
      // Coming out of HOLD keeps the held count so the step resumes where it stopped.
      case (mode_q)
        MODE_AUTO: begin
          if (cnt_q == CNT_LAST) begin
            color_n = color_q + 3'd1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        MODE_HOLD: ;
        default:   cnt_n = '0;
      endcase
    end else begin
      mode_n  = MODE_MANUAL;
      color_n = sw_s;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_MANUAL;
      color_q <= 3'b000;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= last_px;
      if (last_px) begin
        mode_q  <= mode_n;
        color_q <= color_n;
        cnt_q   <= cnt_n;
      end
    end
  end

  assign color      = color_q;
  assign frame_tick = tick_q;
  assign mode       = mode_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_vga_color_sched.sv
// tb/tb_vga_color_sched.sv - self-checking bench for vga_color_sched on a 10x5 frame, 3 frames per step.
module tb_vga_color_sched;

  localparam int HT  = 10;
  localparam int VT  = 5;
  localparam int FPS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h_count = '0;
  logic [9:0]  v_count = '0;
  logic [2:0]  sw = 3'b101;
  logic        auto_en = 1'b0;
  logic        freeze = 1'b0;
  logic [2:0]  color;
  logic        frame_tick;
  logic [1:0]  mode;
  logic [9:0]  frame_cnt;

  int compared = 0;
  int mismatched = 0;

  vga_color_sched #(
    .H_TOTAL         (HT),
    .V_TOTAL         (VT),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .sw         (sw),
    .auto_en    (auto_en),
    .freeze     (freeze),
    .color      (color),
    .frame_tick (frame_tick),
    .mode       (mode),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Free-running stand-in for vga_ctrl's registered counters.
  always @(posedge clk) begin
    if (h_count == 11'(HT - 1)) begin
      h_count <= '0;
      v_count <= (v_count == 10'(VT - 1)) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 11'd1;
    end
  end

  // Behavioural model: inputs seen two clocks late, state applied at each frame end.
  int         m_mode;
  int         m_color;
  int         m_cnt;
  bit         m_tick;
  logic [4:0] hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  = 0;
      m_color = 0;
      m_cnt   = 0;
      m_tick  = 0;
      hist.delete();
    end else begin
      logic [4:0] s;
      bit last;
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 5'b0;
      last = (h_count == 11'(HT - 1)) && (v_count == 10'(VT - 1));
      m_tick = last;
      if (last) begin
        if (s[0]) begin
          m_mode = 2;
        end else if (s[1]) begin
          if (m_mode == 1) begin
            if (m_cnt == FPS - 1) begin
              m_color = (m_color + 1) % 8;
              m_cnt   = 0;
            end else begin
              m_cnt = m_cnt + 1;
            end
          end else if (m_mode == 0) begin
            m_cnt = 0;
          end
          m_mode = 1;
        end else begin
          m_color = int'(s[4:2]);
          m_cnt   = 0;
          m_mode  = 0;
        end
      end
      hist.push_back({sw, auto_en, freeze});
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      compared++;
      if (int'(color) != m_color || int'(mode) != m_mode ||
          int'(frame_cnt) != m_cnt || frame_tick != m_tick) begin
        mismatched++;
        $display("FAIL model @(%0d,%0d): color=%b mode=%0d cnt=%0d tick=%b, required color=%0d mode=%0d cnt=%0d tick=%0d",
                 h_count, v_count, color, mode, frame_cnt, frame_tick, m_color, m_mode, m_cnt, m_tick);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int hh, input int vv);
    int n;
    n = 0;
    @(negedge clk);
    while (!(int'(h_count) == hh && int'(v_count) == vv)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        compared++;
        mismatched++;
        $display("FAIL wait_pos(%0d,%0d): timed out, required the position within 200 cycles", hh, vv);
        return;
      end
    end
  endtask

  logic [2:0] seq [3];

  initial begin
    seq = '{3'b111, 3'b000, 3'b001};

    // 1: reset mid-frame
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_pos(0, 0);
    check("t1_color_pre", int'(color), 5);
    wait_pos(4, 2);
    rst = 1'b1;
    #1;
    check("t1_rst_color", int'(color), 0);
    check("t1_rst_mode", int'(mode), 0);
    check("t1_rst_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pos(9, 4);
    check("t1_before_edge", int'(color), 0);
    wait_pos(0, 0);
    check("t1_after_edge", int'(color), 5);
    check("t1_tick", int'(frame_tick), 1);

    // 2: no tearing on manual change
    sw = 3'b010;
    wait_pos(0, 0);
    check("t2_color_010", int'(color), 2);
    wait_pos(3, 1);
    sw = 3'b110;
    wait_pos(9, 4);
    check("t2_hold_010", int'(color), 2);
    check("t2_tick_low", int'(frame_tick), 0);
    wait_pos(0, 0);
    check("t2_color_110", int'(color), 6);

    // 3: auto cycling through the 7->0 wrap
    wait_pos(5, 0);
    auto_en = 1'b1;
    wait_pos(0, 0);
    check("t3_mode", int'(mode), 1);
    check("t3_color", int'(color), 6);
    check("t3_cnt", int'(frame_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      repeat (3) wait_pos(0, 0);
      check("t3_step", int'(color), int'(seq[i]));
    end

    // 4: freeze while in auto
    wait_pos(0, 0);
    check("t4_cnt1", int'(frame_cnt), 1);
    wait_pos(2, 0);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_pos(0, 0);
      check("t4_hold_mode", int'(mode), 2);
      check("t4_hold_cnt", int'(frame_cnt), 1);
      check("t4_hold_color", int'(color), 1);
    end
    wait_pos(2, 0);
    freeze = 1'b0;
    wait_pos(0, 0);
    check("t4_resume_mode", int'(mode), 1);
    check("t4_resume_cnt", int'(frame_cnt), 1);
    wait_pos(0, 0);
    check("t4_cnt2", int'(frame_cnt), 2);
    check("t4_color_held", int'(color), 1);
    wait_pos(0, 0);
    check("t4_color_next", int'(color), 2);
    check("t4_cnt_clear", int'(frame_cnt), 0);

    // 5: glitch on auto_en inside a frame
    auto_en = 1'b0;
    sw = 3'b011;
    wait_pos(0, 0);
    check("t5_mode", int'(mode), 0);
    check("t5_color", int'(color), 3);
    wait_pos(2, 2);
    auto_en = 1'b1;
    repeat (5) @(negedge clk);
    auto_en = 1'b0;
    wait_pos(0, 0);
    check("t5_glitch_mode", int'(mode), 0);
    check("t5_glitch_color", int'(color), 3);
    sw = 3'b100;
    wait_pos(0, 0);
    check("t5_follow_sw", int'(color), 4);

    // 6: freeze beats auto_en
    wait_pos(1, 1);
    freeze = 1'b1;
    auto_en = 1'b1;
    wait_pos(0, 0);
    check("t6_mode_hold", int'(mode), 2);
    check("t6_cnt", int'(frame_cnt), 0);
    check("t6_color", int'(color), 4);
    wait_pos(1, 1);
    freeze = 1'b0;
    wait_pos(0, 0);
    check("t6_mode_auto", int'(mode), 1);
    check("t6_cnt_kept", int'(frame_cnt), 0);
    wait_pos(0, 0);
    check("t6_cnt_counts", int'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_color_sched.md
# vga_color_sched

Frame-synchronous colour scheduler for the VGA output path. Sits between the `sw` inputs and `rgb_gen` and decides which 3-bit colour is shown. It changes colour only at frame boundaries, so no frame ever shows a tear. Supports three modes: manual (switch-driven), auto-cycle (steps through all 8 colours every N frames) and freeze. Timing is taken from the `h_count`/`v_count` outputs of `vga_ctrl`.

## Interface
- `H_TOTAL`, 1040: total pixel clocks per line, including blanking.
- `V_TOTAL`, 666: total lines per frame, including blanking.
- `FRAMES_PER_STEP`, 60: frames each colour is held in auto mode; legal range 1..1023.
- `clk` in 1: pixel clock, the same clock as `vga_ctrl`.
- `rst` in 1: asynchronous, active-high reset.
- `h_count` in 11: horizontal counter from `vga_ctrl`; registered on `clk`.
- `v_count` in 10: vertical counter from `vga_ctrl`; registered on `clk`.
- `sw` in 3: manual colour select {R,G,B}; asynchronous (board switches).
- `auto_en` in 1: request auto-cycle mode; asynchronous.
- `freeze` in 1: hold the current colour; asynchronous; has priority over `auto_en`.
- `color` out 3: colour to `rgb_gen`, {red,green,blue}.
- `frame_tick` out 1: one-cycle pulse on the first pixel clock of each frame.
- `mode` out 2: current state (00 MANUAL, 01 AUTO, 10 HOLD).
- `frame_cnt` out 10: frames elapsed in the current auto step.

## Operation
- **Input synchronisation:** `sw`, `auto_en` and `freeze` each pass through a 2-flop synchroniser. Only the synchronised values (`*_s`) are used internally.
- **Frame-end detect (combinational):** `last_px` = (`h_count` == H_TOTAL-1) && (`v_count` == V_TOTAL-1).
- All state, `color`, `frame_cnt` and `frame_tick` update only on the clock edge where `last_px` = 1. The one exception is reset.
- **Next state at each `last_px`:**
  - `freeze_s` = 1 → HOLD.
  - Otherwise, `auto_en_s` = 1 → AUTO.
  - Otherwise → MANUAL.
- **Actions at the `last_px` edge, by next state:**
  - MANUAL: `color` <= `sw_s`; `frame_cnt` <= 0.
  - AUTO, entered from another state: `color` unchanged; `frame_cnt` <= 0.
  - AUTO, staying in AUTO:
    - If `frame_cnt` == FRAMES_PER_STEP-1: `color` <= `color`+1 mod 8 (wraps 7→0) and `frame_cnt` <= 0.
    - Otherwise: `frame_cnt` <= `frame_cnt`+1.
  - HOLD: `color` and `frame_cnt` unchanged. Leaving HOLD for AUTO resumes counting from the held `frame_cnt`; it does not clear.
- **Mid-frame changes:** a mode or `sw` change inside a frame has no visible effect until the next frame boundary. If an input toggles and restores entirely within one frame, it has no effect at all.
- **FRAMES_PER_STEP = 1:** the colour increments every frame.
- **Out-of-range counts:** `h_count`/`v_count` values ≥ TOTAL never match `last_px`, so the outputs hold.
- **Reset:** asynchronous assertion forces `color`=000, `mode`=MANUAL, `frame_cnt`=0, `frame_tick`=0 and clears the synchronisers. This applies immediately, even mid-frame. After deassertion, the first update happens at the next `last_px`.

## Timing
- **`frame_tick`:** registered from `last_px`. It is high exactly in the cycle where `h_count`=0 and `v_count`=0, and low at all other times.
- **`color` alignment:** `color` changes on the same edge that `frame_tick` rises, so the new colour covers pixel (0,0) onward.
- **Input-to-output latency:** 2 cycles of synchroniser, plus the wait to the next `last_px`.
  - Best case: 3 cycles.
  - Worst case: H_TOTAL·V_TOTAL + 2 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- **Shared package `vga_pkg`:**
  - H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE and the sync timing constants. These are shared with `vga_ctrl`.
  - Mode encodings MODE_MANUAL, MODE_AUTO and MODE_HOLD.
  - Count widths: 11 horizontal, 10 vertical.
- **Sub-module `sync_2ff`:** parameterised width, reset-clearable. Instantiate it once with width 5 to cover {`sw`, `auto_en`, `freeze`}.
- **Main FSM and counters:** one always block for the registers and one for next-state logic. Target 150–250 lines of RTL in total.

## Test plan
Bench settings: H_TOTAL=10, V_TOTAL=5, FRAMES_PER_STEP=3. The bench models the counters (wrap-around, 50-cycle frames).
1. **Reset mid-frame.** Run with `sw`=101, then assert `rst` at count (4,2). Expect `color`=000, `mode`=00 and `frame_cnt`=0 immediately. After release, `color`=101 only from the next (0,0).
2. **Manual tearing check.** Change `sw` 010→110 at count (3,1). Expect `color` to stay 010 until (0,0) and become 110 there. Expect `frame_tick` high only at (0,0) each frame.
3. **Auto cycling.** Set `auto_en`=1 with `color`=110. Expect `color` sequence 110, 111, 000, 001, each held for 3 frames (150 cycles). This verifies the 7→0 wrap.
4. **Freeze in auto.** Assert `freeze` at `frame_cnt`=1, hold for 4 frames, then release. Expect `mode`=10, with `color` and `frame_cnt`=1 frozen. After release, expect 1 more frame before the colour increments.
5. **Glitch rejection.** Pulse `auto_en` high for 5 cycles inside one frame. Expect `mode` to stay 00 and `color` to keep following `sw`.
6. **Priority.** Assert `freeze` and `auto_en` together from MANUAL. Expect `mode`=10 at the next boundary. Then drop `freeze`: expect `mode`=01 with `frame_cnt` unchanged.
